// File: rtl/alu_pkg.sv
// Shared definitions for the multicycle ALU: op indices, FSM states and
// the radix-4 Booth digit recoder used by the multiply step.
package alu_pkg;

    localparam int NUM_OPS = 12;

    localparam int ALU_ADD = 0;
    localparam int ALU_SUB = 1;
    localparam int ALU_SHR = 2;
    localparam int ALU_SHL = 3;
    localparam int ALU_ROR = 4;
    localparam int ALU_ROL = 5;
    localparam int ALU_AND = 6;
    localparam int ALU_OR  = 7;
    localparam int ALU_MUL = 8;
    localparam int ALU_DIV = 9;
    localparam int ALU_NEG = 10;
    localparam int ALU_NOT = 11;

    typedef enum logic [2:0] {
        IDLE,
        MUL,
        DIV,
        FIX,
        FIN
    } alu_state_t;

    // Digit in -2..+2 (3-bit two's complement) for the triple {b[2i+1], b[2i], b[2i-1]}.
    function automatic logic [2:0] booth_recode(input logic [2:0] bits);
        logic [2:0] d;
        case (bits)
            3'b001, 3'b010: d = 3'b001;
            3'b011:         d = 3'b010;
            3'b100:         d = 3'b110;
            3'b101, 3'b110: d = 3'b111;
            default:        d = 3'b000;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/alu_multicycle_if.sv
// Request/result bundle between the datapath controller (master) and the ALU (slave).
// start is sampled on a rising edge only while busy=0; busy stays high while a long op
// runs; done pulses for one cycle with results valid, and a start in that cycle is accepted.
interface alu_multicycle_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [11:0]      select;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] z;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             div_by_zero;

    modport master (
        output start, select, a, b,
        input  busy, done, z, hi, lo, div_by_zero
    );

    modport slave (
        input  start, select, a, b,
        output busy, done, z, hi, lo, div_by_zero
    );

endinterface

// File: rtl/alu_div_core.sv
// Signed truncating divider: non-restoring iteration on magnitudes, one quotient bit
// per cycle, with remainder restore and sign fix-up applied combinationally on the result.
module alu_div_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_ready,
    output logic [WIDTH-1:0] o_quot,
    output logic [WIDTH-1:0] o_rem
);
    localparam int CW = $clog2(WIDTH);

    logic             r_run;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH+1:0] r_p;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_m;
    logic             r_neg_q;
    logic             r_neg_r;

    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic [WIDTH+1:0] w_shift;
    logic [WIDTH+1:0] w_m_ext;
    logic [WIDTH+1:0] w_p_next;
    logic [WIDTH-1:0] w_rem_mag;

    assign w_abs_a  = i_a[WIDTH-1] ? -i_a : i_a;
    assign w_abs_b  = i_b[WIDTH-1] ? -i_b : i_b;
    assign w_m_ext  = {2'b00, r_m};
    assign w_shift  = {r_p[WIDTH:0], r_q[WIDTH-1]};
    assign w_p_next = r_p[WIDTH+1] ? (w_shift + w_m_ext) : (w_shift - w_m_ext);

    // High during the final iteration; the fixed-up result is valid from the next cycle.
    assign o_ready = r_run && (r_cnt == CW'(WIDTH - 1));

    assign w_rem_mag = r_p[WIDTH-1:0] + (r_p[WIDTH+1] ? r_m : '0);
    assign o_quot    = r_neg_q ? -r_q : r_q;
    assign o_rem     = r_neg_r ? -w_rem_mag : w_rem_mag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run   <= 1'b0;
            r_cnt   <= '0;
            r_p     <= '0;
            r_q     <= '0;
            r_m     <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else if (i_start) begin
            r_run   <= 1'b1;
            r_cnt   <= '0;
            r_p     <= '0;
            r_q     <= w_abs_a;
            r_m     <= w_abs_b;
            r_neg_q <= i_a[WIDTH-1] ^ i_b[WIDTH-1];
            r_neg_r <= i_a[WIDTH-1];
        end else if (r_run) begin
            r_p   <= w_p_next;
            r_q   <= {r_q[WIDTH-2:0], ~w_p_next[WIDTH+1]};
            r_cnt <= r_cnt + CW'(1);
            if (o_ready) begin
                r_run <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_multicycle.sv
// Registered ALU: simple ops finish in one cycle, mul runs a radix-4 Booth loop inline,
// div is delegated to alu_div_core. Current FSM state is exported on o_state.
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_multicycle_if.slave    bus,
    output alu_state_t         o_state
);
    localparam int CW = $clog2(WIDTH);
    localparam int PW = 2 * WIDTH;

    alu_state_t       r_state;
    alu_state_t       w_next;

    logic             w_onehot;
    logic             w_is_mul;
    logic             w_is_div;
    logic             w_b_zero;
    logic             w_accept;
    logic             w_div_start;
    logic             w_div_ready;
    logic             w_mul_last;
    logic [SHW-1:0]   w_amt;
    logic [SHW-1:0]   w_amt_neg;
    logic [WIDTH-1:0] w_simple;
    logic [WIDTH-1:0] w_div_quot;
    logic [WIDTH-1:0] w_div_rem;
    logic [2:0]       w_digit;
    logic [PW-1:0]    w_pp;
    logic [PW-1:0]    w_prod_next;

    logic [PW-1:0]    r_mcand;
    logic [PW-1:0]    r_prod;
    logic [WIDTH:0]   r_mplier;
    logic [CW-1:0]    r_mcnt;
    logic [WIDTH-1:0] r_z;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_dbz;

    assign w_onehot    = (bus.select != '0) &&
                         ((bus.select & (bus.select - NUM_OPS'(1))) == '0);
    assign w_is_mul    = w_onehot & bus.select[ALU_MUL];
    assign w_is_div    = w_onehot & bus.select[ALU_DIV];
    assign w_b_zero    = (bus.b == '0);
    assign w_accept    = bus.start && ((r_state == IDLE) || (r_state == FIN));
    assign w_div_start = w_accept && w_is_div && !w_b_zero;
    assign w_mul_last  = (r_mcnt == CW'(WIDTH / 2 - 1));

    // Rotates use the complementary amount modulo 2^SHW; amount 0 ORs a with itself.
    assign w_amt     = bus.b[SHW-1:0];
    assign w_amt_neg = -w_amt;

    always_comb begin
        w_simple = '0;
        if (w_onehot) begin
            if (bus.select[ALU_ADD]) w_simple = bus.a + bus.b;
            if (bus.select[ALU_SUB]) w_simple = bus.a - bus.b;
            if (bus.select[ALU_SHR]) w_simple = bus.a >> w_amt;
            if (bus.select[ALU_SHL]) w_simple = bus.a << w_amt;
            if (bus.select[ALU_ROR]) w_simple = (bus.a >> w_amt) | (bus.a << w_amt_neg);
            if (bus.select[ALU_ROL]) w_simple = (bus.a << w_amt) | (bus.a >> w_amt_neg);
            if (bus.select[ALU_AND]) w_simple = bus.a & bus.b;
            if (bus.select[ALU_OR])  w_simple = bus.a | bus.b;
            if (bus.select[ALU_NEG]) w_simple = -bus.b;
            if (bus.select[ALU_NOT]) w_simple = ~bus.b;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE, FIN: begin
                w_next = IDLE;
                if (bus.start) begin
                    if (w_is_mul)         w_next = MUL;
                    else if (w_div_start) w_next = DIV;
                    else                  w_next = FIN;
                end
            end
            MUL:     if (w_mul_last)  w_next = FIN;
            DIV:     if (w_div_ready) w_next = FIX;
            FIX:     w_next = FIN;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    assign w_digit = booth_recode(r_mplier[2:0]);

    always_comb begin
        w_pp = '0;
        case (w_digit)
            3'b001:  w_pp = r_mcand;
            3'b010:  w_pp = r_mcand << 1;
            3'b111:  w_pp = -r_mcand;
            3'b110:  w_pp = -(r_mcand << 1);
            default: w_pp = '0;
        endcase
    end

    assign w_prod_next = r_prod + w_pp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand  <= '0;
            r_prod   <= '0;
            r_mplier <= '0;
            r_mcnt   <= '0;
            r_z      <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_dbz    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_dbz <= w_is_div && w_b_zero;
                if (w_is_mul) begin
                    r_mcand  <= {{WIDTH{bus.a[WIDTH-1]}}, bus.a};
                    r_mplier <= {bus.b, 1'b0};
                    r_prod   <= '0;
                    r_mcnt   <= '0;
                end else if (w_is_div) begin
                    if (w_b_zero) begin
                        r_hi <= bus.a;
                        r_lo <= '1;
                    end
                end else begin
                    r_z <= w_simple;
                end
            end
            if (r_state == MUL) begin
                r_prod   <= w_prod_next;
                r_mcand  <= r_mcand << 2;
                r_mplier <= r_mplier >> 2;
                r_mcnt   <= r_mcnt + CW'(1);
                if (w_mul_last) begin
                    {r_hi, r_lo} <= w_prod_next;
                end
            end
            if (r_state == FIX) begin
                r_hi <= w_div_rem;
                r_lo <= w_div_quot;
            end
        end
    end

    alu_div_core #(
        .WIDTH (WIDTH)
    ) u_div (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (w_div_start),
        .i_a     (bus.a),
        .i_b     (bus.b),
        .o_ready (w_div_ready),
        .o_quot  (w_div_quot),
        .o_rem   (w_div_rem)
    );

    assign bus.busy        = (r_state == MUL) || (r_state == DIV) || (r_state == FIX);
    assign bus.done        = (r_state == FIN);
    assign bus.z           = r_z;
    assign bus.hi          = r_hi;
    assign bus.lo          = r_lo;
    assign bus.div_by_zero = r_dbz;
    assign o_state         = r_state;

endmodule

// File: tb/tb_alu_multicycle.sv
// Bench for alu_multicycle at WIDTH=32: directed spec cases, random ops against an
// arithmetic reference model, ignored starts while busy, and reset mid-multiply.
module tb_alu_multicycle;
    import alu_pkg::*;

    localparam int W = 32;

    typedef struct {
        logic [W-1:0] z;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
        int           cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    alu_state_t dbg_state;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   exp_busy = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    logic [W-1:0] m_z = '0;
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;
    logic         m_dbz = 1'b0;

    alu_multicycle_if #(.WIDTH(W)) bus();

    alu_multicycle #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .o_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] sel1(input int i);
        logic [11:0] s;
        s = '0;
        s[i] = 1'b1;
        return s;
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return 32'h1;
            2:       return '1;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return W'($urandom);
        endcase
    endfunction

    // ---------------- driver ----------------
    task automatic issue(input logic [11:0] sel, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t       e;
        int         n;
        int         idx;
        int         amt;
        longint     la;
        longint     lb;
        longint     prod;
        longint     q;
        longint     r;
        n     = 1;
        amt   = int'(b[4:0]);
        la    = longint'($signed(a));
        lb    = longint'($signed(b));
        m_dbz = 1'b0;
        if ($countones(sel) == 1) begin
            idx = 0;
            for (int i = 0; i < 12; i++) if (sel[i]) idx = i;
            case (idx)
                ALU_ADD: m_z = a + b;
                ALU_SUB: m_z = a - b;
                ALU_SHR: m_z = a >> amt;
                ALU_SHL: m_z = a << amt;
                ALU_ROR: m_z = (a >> amt) | (a << (32 - amt));
                ALU_ROL: m_z = (a << amt) | (a >> (32 - amt));
                ALU_AND: m_z = a & b;
                ALU_OR:  m_z = a | b;
                ALU_NEG: m_z = -b;
                ALU_NOT: m_z = ~b;
                ALU_MUL: begin
                    prod = la * lb;
                    {m_hi, m_lo} = prod;
                    n = W / 2 + 1;
                end
                default: begin
                    if (b == '0) begin
                        m_hi  = a;
                        m_lo  = '1;
                        m_dbz = 1'b1;
                    end else begin
                        q    = la / lb;
                        r    = la % lb;
                        m_lo = q[31:0];
                        m_hi = r[31:0];
                        n    = W + 2;
                    end
                end
            endcase
        end else begin
            m_z = '0;
        end
        bus.start  = 1'b1;
        bus.select = sel;
        bus.a      = a;
        bus.b      = b;
        exp_busy   = n - 1;
        @(posedge clk);
        #1;
        e.z   = m_z;
        e.hi  = m_hi;
        e.lo  = m_lo;
        e.dbz = m_dbz;
        e.cyc = cyc + n - 1;
        exp_q.push_back(e);
        bus.start  = 1'b0;
        bus.select = 12'($urandom);
        bus.a      = W'($urandom);
        bus.b      = W'($urandom);
    endtask

    task automatic wait_done();
        int busy_cnt;
        bit got;
        busy_cnt = 0;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (bus.done) begin
                got = 1'b1;
                chk("busy_at_done", bus.busy, 0);
            end else if (bus.busy) begin
                busy_cnt++;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL done_timeout actual=no_done expected=done");
        end else begin
            chk("busy_cycles", busy_cnt, exp_busy);
        end
    endtask

    task automatic run_op(input logic [11:0] sel, input logic [W-1:0] a, input logic [W-1:0] b);
        issue(sel, a, b);
        wait_done();
    endtask

    task automatic reset_model();
        exp_q.delete();
        m_z   = '0;
        m_hi  = '0;
        m_lo  = '0;
        m_dbz = 1'b0;
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual=done expected=no_done");
            end else begin
                mon_e = exp_q.pop_front();
                chk("z", bus.z, mon_e.z);
                chk("hi", bus.hi, mon_e.hi);
                chk("lo", bus.lo, mon_e.lo);
                chk("div_by_zero", bus.div_by_zero, mon_e.dbz);
                chk("latency_cycle", cyc, mon_e.cyc);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [11:0] sel;
        logic [W-1:0] a;
        logic [W-1:0] b;
        int r;

        bus.start  = 1'b0;
        bus.select = '0;
        bus.a      = '0;
        bus.b      = '0;
        rst_n      = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_busy", bus.busy, 0);
        chk("reset_done", bus.done, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_z", bus.z, 0);
        chk("reset_hi", bus.hi, 0);
        chk("reset_lo", bus.lo, 0);
        chk("reset_dbz", bus.div_by_zero, 0);
        chk("reset_state", dbg_state, IDLE);

        run_op(sel1(ALU_ADD), 32'h7C, 32'd7);
        chk("add_literal", bus.z, 131);
        run_op(sel1(ALU_SUB), 32'h7C, 32'd7);
        chk("sub_literal", bus.z, 117);
        run_op(sel1(ALU_ROR), 32'h1, 32'h1);
        chk("ror_literal", bus.z, 32'h8000_0000);
        run_op(sel1(ALU_ROL), 32'h1, 32'h1);
        run_op(sel1(ALU_SHR), 32'h8000_0000, 32'd35);
        chk("shr_literal", bus.z, 32'h1000_0000);
        run_op(sel1(ALU_MUL), 32'hFFFF_FFFD, 32'd7);
        chk("mul_lo_literal", bus.lo, 32'hFFFF_FFEB);
        run_op(sel1(ALU_MUL), 32'd124, 32'd7);
        run_op(sel1(ALU_DIV), 32'hFFFF_FFF9, 32'd2);
        chk("div_lo_literal", bus.lo, 32'hFFFF_FFFD);
        run_op(sel1(ALU_DIV), 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(sel1(ALU_DIV), 32'd5, 32'd0);
        chk("dbz_literal", bus.div_by_zero, 1);
        run_op(sel1(ALU_ADD), 32'd1, 32'd2);
        run_op(12'h000, 32'd9, 32'd9);
        run_op(12'h003, 32'd9, 32'd9);
        run_op(sel1(ALU_NEG), 32'd9, 32'd5);
        run_op(sel1(ALU_NOT), 32'd9, 32'h0F0F_0F0F);
        run_op(sel1(ALU_AND), 32'hFF00_FF00, 32'h0FF0_0FF0);
        run_op(sel1(ALU_OR), 32'hFF00_FF00, 32'h0FF0_0FF0);
        run_op(sel1(ALU_SHL), 32'h0000_00F1, 32'd36);
        run_op(sel1(ALU_ROL), 32'h8000_0001, 32'd0);

        repeat (60) begin
            a = pick();
            b = pick();
            r = int'($urandom_range(0, 15));
            if (r < 12)       sel = sel1(r);
            else if (r == 12) sel = '0;
            else if (r == 13) sel = 12'($urandom);
            else if (r == 14) begin
                sel = sel1(ALU_DIV);
                b   = '0;
            end else          sel = sel1(ALU_MUL);
            run_op(sel, a, b);
        end

        run_op(sel1(ALU_MUL), 32'h0001_2345, 32'h0000_6789);
        run_op(sel1(ALU_ADD), 32'h1111_1111, 32'h2222_2222);
        issue(sel1(ALU_MUL), 32'hFFFF_FFFD, 32'd7);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            chk("busy_during_mul", bus.busy, 1);
            bus.start  = 1'b1;
            bus.select = sel1(ALU_ADD);
            bus.a      = W'($urandom);
            bus.b      = W'($urandom);
        end
        @(negedge clk);
        bus.start = 1'b0;
        rst_n     = 1'b0;
        reset_model();
        #1;
        chk("abort_z", bus.z, 0);
        chk("abort_hi", bus.hi, 0);
        chk("abort_lo", bus.lo, 0);
        chk("abort_busy", bus.busy, 0);
        chk("abort_done", bus.done, 0);
        chk("abort_state", dbg_state, IDLE);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("no_done_after_abort", bus.done, 0);
        end
        run_op(sel1(ALU_ADD), 32'd5, 32'd6);
        chk("add_after_abort", bus.z, 11);

        repeat (2) @(negedge clk);
        chk("exp_q_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_multicycle.md
# alu_multicycle

Parametrised, registered successor to the single-cycle ALU. It executes the same twelve one-hot operations, including complete shift-right, rotate and divide. Multiply is an iterative radix-4 Booth engine and divide is an iterative non-restoring engine. A start/busy/done handshake lets the datapath controller stall on long operations while simple operations still complete in one cycle.

## Interface
- WIDTH, 32, operand width. Must be even and at least 4.
- SHW, $clog2(WIDTH), number of low bits of b used as the shift/rotate amount.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only while busy=0
- select  in  12  one-hot op: bit0 add, 1 sub, 2 shr, 3 shl, 4 ror, 5 rol, 6 and, 7 or, 8 mul, 9 div, 10 neg, 11 not
- a, b  in  WIDTH  operands; captured on the accepted start
- busy  out  1  high from the accept cycle +1 until done
- done  out  1  one-cycle pulse when results are valid
- z  out  WIDTH  result for non-mul/div ops
- hi, lo  out  WIDTH  mul: {hi,lo} = product; div: hi = remainder, lo = quotient
- div_by_zero  out  1  set with done when div has b=0; cleared on next accept

## Operation
- States:
  - IDLE: start=1 accepts; a, b, select are latched.
    - select is a simple op, or not one-hot including zero: go to FIN.
    - select is mul: go to MUL.
    - select is div with b≠0: go to DIV.
    - select is div with b=0: go to FIN.
  - MUL: WIDTH/2 cycles.
  - DIV: WIDTH cycles.
  - FIX: one cycle.
  - FIN: done=1, then return to IDLE.
- Simple ops are computed on the latched operands:
  - add/sub wrap modulo 2^WIDTH.
  - shr is logical.
  - shl, ror and rol use amount b[SHW-1:0].
  - neg = -b, not = ~b.
  - An invalid select gives z=0.
- Mul is signed two's complement with a 2·WIDTH product.
  - Each MUL cycle retires one Booth bit-pair (recode b[2i+1:2i-1]).
  - The partial product is one of 0, ±a or ±2a, sign-extended.
- Div is signed and truncating; the remainder takes the dividend's sign.
  - DIV works on magnitudes, one quotient bit per cycle.
  - FIX restores the remainder and applies signs.
  - (-2^(WIDTH-1)) / -1 gives lo = 2^(WIDTH-1) (wraps) and hi = 0.
- Divide by zero: lo = all ones, hi = a, div_by_zero = 1.
- Output update rules:
  - z updates only on simple-op completion; mul/div leave z unchanged.
  - hi/lo update only on mul/div completion.
  - All outputs hold between completions.
- start while busy=1 is ignored; there is no queueing.

## Timing
- Reset (rst_n=0, takes effect immediately): state IDLE; busy, done, z, hi, lo, div_by_zero = 0.
- Latency, counted as done asserted N cycles after the accept edge:
  - simple, invalid, div-by-zero: N=1, busy never rises.
  - mul: N = WIDTH/2+1 (17 at WIDTH=32).
  - div: N = WIDTH+2 (34).
- busy falls in the same cycle done rises. A start in that cycle is accepted, giving back-to-back throughput.
- Reset mid-operation aborts the operation: no done pulse, and outputs return to 0.
- A change in a, b or select after accept has no effect.

## Structure
- Package alu_pkg holds:
  - select index constants ALU_ADD … ALU_NOT (0–11);
  - the state enum {IDLE, MUL, DIV, FIX, FIN};
  - the Booth recode function.
- Sub-module alu_div_core holds the non-restoring divider iteration register, cycle counter and sign fix-up, with a start/ready interface to the top-level FSM.
- The multiply step stays inline in the top level.

## Test plan
All cases use WIDTH=32.
- Reset, then add a=0x7C, b=7: done at +1, z=131. sub gives 117. Reset values are checked before the first start.
- ror a=0x0000_0001, b=1: z=0x8000_0000. rol same operands: z=0x0000_0002. shr a=0x8000_0000, b=35: z=0x1000_0000 (amount 3).
- mul a=-3, b=7: busy for 16 cycles, done at +17, hi=0xFFFF_FFFF, lo=0xFFFF_FFEB. mul 124·7 gives lo=868, hi=0.
- div a=-7, b=2: done at +34, lo=-3, hi=-1. div a=0x8000_0000, b=-1: lo=0x8000_0000, hi=0.
- div b=0, a=5: done at +1, div_by_zero=1, lo=0xFFFF_FFFF, hi=5. The next add clears div_by_zero.
- Mul in progress with start pulses every cycle: the pulses are ignored. Assert rst_n=0 at +8: no done, outputs 0. After release, a new add completes normally.
